time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Keypad-driven time-entry sequencer for the 1 kHz wall-clock watch. It debounces the keypad and runs an HH:MM:SS entry session. Each digit is range-checked as it is entered. The block emits a one-cycle load strobe with six BCD digits, which the watch counter datapath loads. It also drives editing, cursor and blink status to the seven-segment scan logic.

Parameters:
DEBOUNCE, 20, cycles a synchronized key level must be stable before a press or release is accepted
TIMEOUT, 10000, cycles without an accepted press in ENTRY before the session aborts
BLINK_HALF, 500, half-period in cycles of the cursor blink

Ports:
clk  in  1  system clock, 1 kHz nominal
rst  in  1  asynchronous, active-high reset
key_valid  in  1  asynchronous level, high while any key is held
key_code  in  4  key id, qualified by key_valid: 0-9 digits, 10 '*' cancel, 11 '#' set, 12-15 unused
load  out  1  one-cycle strobe; load_digits is valid in this cycle
load_digits  out  24  {h_ten,h_one,m_ten,m_one,s_ten,s_one} BCD, h_ten at [23:20]
editing  out  1  high while in ENTRY; the watch freezes counting while high
cursor  out  3  index 0-5 of the digit being entered
blink  out  1  cursor blink phase
err  out  1  one-cycle pulse on a rejected digit
abort  out  1  one-cycle pulse on cancel or timeout

Behaviour:
- Reset (async, any state): state goes to IDLE. load, editing, blink, err and abort are 0. cursor is 0, load_digits is 0, the debounce and timeout counters are 0, and the staged digits are 0. No load is issued.
- Input path: key_valid and key_code each pass through 2-flop synchronizers.
- Debounce: a press event (1 cycle) fires when the synchronized key_valid has been high for DEBOUNCE consecutive cycles. The synchronized key_code is captured in that cycle. Total latency is DEBOUNCE+2 edges from the first edge that samples key_valid high.
- Re-arm: no further press is accepted until key_valid has been low for DEBOUNCE consecutive cycles. Holding a key yields exactly one event.
- Glitch: a low blip shorter than DEBOUNCE restarts the count and produces no event.
- FSM states: IDLE, ENTRY, COMMIT.
- IDLE:
  - Press '#' -> ENTRY, with cursor=0, staged digits=0, timeout=0.
  - All other keys are ignored, with no err or abort.
- ENTRY, digit press at cursor c, limits:
  - c0 <= 2
  - c1 <= 9, but <= 3 if staged h_ten == 2
  - c2 <= 5
  - c3 <= 9
  - c4 <= 5
  - c5 <= 9
- ENTRY, valid digit: store it, clear timeout. If c < 5, cursor++. If c == 5 -> COMMIT.
- ENTRY, invalid digit: err=1 for 1 cycle. The digit is not stored, cursor is unchanged, and timeout is cleared.
- ENTRY, other keys:
  - '*': abort=1 for 1 cycle -> IDLE, cursor=0, no load.
  - '#' and codes 12-15: ignored, and timeout is not cleared.
- ENTRY, timeout: the counter increments every cycle with no accepted press. When it reaches TIMEOUT-1, abort=1 for 1 cycle -> IDLE, no load.
- ENTRY, simultaneous events: if a press event and the timeout terminal count occur in the same cycle, the press wins and the timeout is cleared.
- COMMIT (exactly 1 cycle):
  - load=1 and load_digits = staged digits, registered so both are valid in the same cycle.
  - editing=0 in this cycle, then -> IDLE with cursor=0.
  - load_digits holds its last committed value until the next COMMIT.
- editing = (state == ENTRY), registered.
- blink: toggles every BLINK_HALF cycles while in ENTRY, starting at 1 on entry. Forced 0 outside ENTRY.
- Press events arriving during COMMIT are dropped. Debounce re-arm still applies.
- Width rules: the debounce counter is wide enough for DEBOUNCE, and the timeout counter wide enough for TIMEOUT-1. There is no wrap inside ENTRY, because timeout exits first.

Decomposition:
- Shared package watch_pkg holds:
  - key code constants: KEY_STAR=10, KEY_HASH=11
  - state enum: IDLE / ENTRY / COMMIT
  - per-position digit limit constants: 2, 9, 5, 9, 5, 9, plus the h_one limit of 3 when h_ten is 2
- One sub-module, key_debounce: synchronizers plus the debounce/re-arm counter. It outputs press (1-cycle) and code[3:0].
- time_set_ctrl instantiates key_debounce and holds the FSM, range checks, timeout and blink.

Test Plan:
- All tests run with DEBOUNCE=2, TIMEOUT=50, BLINK_HALF=4.
- Full entry: '#', then 2,3,5,9,5,9 with clean presses -> single load pulse with load_digits=0x235959; editing high from the '#' press until the COMMIT cycle; cursor sequence 0..5.
- Range rejection: in ENTRY press 3 at c0 -> err pulse, cursor stays 0. Then press 2, then 4 -> err, cursor stays 1. Then press 3 -> cursor 2.
- Cancel and timeout: '#', 1, '*' -> abort pulse, no load, load_digits unchanged. Then '#' and no keys for 50 cycles -> abort on cycle 50, state IDLE.
- Debounce: key_valid glitch high for 1 cycle -> no event. Key held for 200 cycles -> exactly one event. Re-press after a 1-cycle low -> ignored.
- Async reset asserted mid-cursor 3 -> all outputs 0 immediately. After release, digits are ignored until '#'. load_digits=0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-entry logic: key codes, sequencer states, digit limits.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package watch_pkg;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Largest legal BCD value at each cursor position of HH:MM:SS
   localparam logic [3:0] LIM_H_TEN    = 4'd2;
   localparam logic [3:0] LIM_H_ONE    = 4'd9;
   localparam logic [3:0] LIM_H_ONE_20 = 4'd3;  // hours 20-23 only
   localparam logic [3:0] LIM_M_TEN    = 4'd5;
   localparam logic [3:0] LIM_M_ONE    = 4'd9;
   localparam logic [3:0] LIM_S_TEN    = 4'd5;
   localparam logic [3:0] LIM_S_ONE    = 4'd9;

   function automatic logic [3:0] digit_limit(input logic [2:0] pos, input logic [3:0] h_ten);
      logic [3:0] lim;
      case (pos)
         3'd0:    lim = LIM_H_TEN;
         3'd1:    lim = (h_ten == 4'd2) ? LIM_H_ONE_20 : LIM_H_ONE;
         3'd2:    lim = LIM_M_TEN;
         3'd3:    lim = LIM_M_ONE;
         3'd4:    lim = LIM_S_TEN;
         default: lim = LIM_S_ONE;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad synchronizer and debouncer producing one press pulse per accepted key-down.
// Latency: press fires DEBOUNCE+2 edges after the first edge that samples key_valid high.
// Backpressure: none; after a press, key_valid must be low DEBOUNCE cycles before re-arming.
// Ports: clk, rst (async high); key_valid/key_code raw async keypad inputs;
//        press 1-cycle event, code key id captured with the press (held until the next one).
module key_debounce #(
   parameter int DEBOUNCE = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       press,
   output logic [3:0] code
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic          v_s1, v_s2;
   logic [3:0]    c_s1, c_s2;
   logic          armed;     // 1: waiting for a stable high, 0: waiting for a stable low
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_s1  <= 1'b0;
         v_s2  <= 1'b0;
         c_s1  <= '0;
         c_s2  <= '0;
         armed <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
         code  <= '0;
      end else begin
         v_s1  <= key_valid;
         v_s2  <= v_s1;
         c_s1  <= key_code;
         c_s2  <= c_s1;
         press <= 1'b0;
         // One counter serves both the press and the re-arm qualification;
         // any sample at the wrong level restarts the run.
         if (v_s2 != armed) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            armed <= ~armed;
            if (armed) begin
               press <= 1'b1;
               code  <= c_s2;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad HH:MM:SS entry sequencer: range-checks digits and issues a load strobe to the watch counter.
// Latency: outputs are registered one edge after the debounced press that causes them.
// Backpressure: none; presses arriving during the single COMMIT cycle are dropped.
// Ports: clk, rst (async high); key_valid/key_code raw keypad; load + load_digits commit strobe;
//        editing/cursor/blink display status; err rejected-digit pulse; abort cancel/timeout pulse.
module time_set_ctrl
   import watch_pkg::*;
#(
   parameter int DEBOUNCE   = 20,
   parameter int TIMEOUT    = 10000,
   parameter int BLINK_HALF = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        load,
   output logic [23:0] load_digits,
   output logic        editing,
   output logic [2:0]  cursor,
   output logic        blink,
   output logic        err,
   output logic        abort
);

   localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic            press;
   logic [3:0]      code;

   state_t          state, state_nxt;
   logic [2:0]      cursor_nxt;
   logic [5:0][3:0] staged, staged_nxt;  // staged[5] is h_ten, matching load_digits packing
   logic [TW-1:0]   tmo, tmo_nxt;
   logic [BW-1:0]   bcnt;
   logic            err_nxt, abort_nxt;
   logic [2:0]      idx;
   logic [3:0]      lim;

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .press     (press),
      .code      (code)
   );

   assign idx = 3'd5 - cursor;
   assign lim = digit_limit(cursor, staged[5]);

   always_comb begin
      state_nxt  = state;
      cursor_nxt = cursor;
      staged_nxt = staged;
      tmo_nxt    = tmo;
      err_nxt    = 1'b0;
      abort_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (press && code == KEY_HASH) begin
               state_nxt  = ENTRY;
               cursor_nxt = 3'd0;
               staged_nxt = '0;
               tmo_nxt    = '0;
            end
         end
         ENTRY: begin
            // A press always beats the timeout terminal count
            if (press && code <= 4'd9) begin
               tmo_nxt = '0;
               if (code <= lim) begin
                  staged_nxt[idx] = code;
                  if (cursor == 3'd5) state_nxt  = COMMIT;
                  else                cursor_nxt = cursor + 3'd1;
               end else begin
                  err_nxt = 1'b1;
               end
            end else if (press && code == KEY_STAR) begin
               abort_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (tmo == TW'(TIMEOUT - 1)) begin
               abort_nxt = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != ENTRY) cursor_nxt = 3'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cursor      <= '0;
         staged      <= '0;
         tmo         <= '0;
         bcnt        <= '0;
         load        <= 1'b0;
         load_digits <= '0;
         editing     <= 1'b0;
         blink       <= 1'b0;
         err         <= 1'b0;
         abort       <= 1'b0;
      end else begin
         state   <= state_nxt;
         cursor  <= cursor_nxt;
         staged  <= staged_nxt;
         tmo     <= tmo_nxt;
         err     <= err_nxt;
         abort   <= abort_nxt;
         editing <= (state_nxt == ENTRY);
         load    <= (state_nxt == COMMIT);
         if (state_nxt == COMMIT) load_digits <= staged_nxt;
         // Blink starts lit on entry so the cursor is visible immediately
         if (state_nxt != ENTRY) begin
            blink <= 1'b0;
            bcnt  <= '0;
         end else if (state != ENTRY) begin
            blink <= 1'b1;
            bcnt  <= '0;
         end else if (bcnt == BW'(BLINK_HALF - 1)) begin
            blink <= ~blink;
            bcnt  <= '0;
         end else begin
            bcnt <= bcnt + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized key traffic against a behavioural model.
// Latency: model predicts outputs after each clock edge; compared on the falling edge.
// Backpressure: none.
module tb_time_set_ctrl;

   localparam int D  = 2;
   localparam int T  = 50;
   localparam int BH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        load;
   logic [23:0] load_digits;
   logic        editing;
   logic [2:0]  cursor;
   logic        blink;
   logic        err;
   logic        abort;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   time_set_ctrl #(.DEBOUNCE(D), .TIMEOUT(T), .BLINK_HALF(BH)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .load        (load),
      .load_digits (load_digits),
      .editing     (editing),
      .cursor      (cursor),
      .blink       (blink),
      .err         (err),
      .abort       (abort)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Key level history: samp[i] is key_valid as seen at the edge i edges ago.
   bit         samp  [0:31];
   logic [3:0] csamp [0:31];
   bit         armed;
   bit         pend;
   logic [3:0] pcode;
   int         m_state;        // 0 idle, 1 entry, 2 commit
   int         m_cur;
   int         m_dig [0:5];
   int         m_quiet;        // consecutive entry cycles with no accepted press
   int         m_age;          // cycles since entering entry
   bit         e_load, e_err, e_abort;
   logic [23:0] e_ld;

   function automatic int lim_of(input int c, input int h_ten);
      if (c == 0) return 2;
      if (c == 1) return (h_ten == 2) ? 3 : 9;
      return (c % 2 == 0) ? 5 : 9;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin samp[i] = 1'b0; csamp[i] = 4'd0; end
         armed = 1'b1; pend = 1'b0; pcode = 4'd0;
         m_state = 0; m_cur = 0; m_quiet = 0; m_age = 0;
         for (int i = 0; i < 6; i++) m_dig[i] = 0;
         e_load = 1'b0; e_err = 1'b0; e_abort = 1'b0; e_ld = 24'd0;
      end else begin
         e_load = 1'b0; e_err = 1'b0; e_abort = 1'b0;
         if (m_state == 2) begin
            m_state = 0;
         end else if (m_state == 0) begin
            if (pend && pcode == 4'd11) begin
               m_state = 1; m_cur = 0; m_quiet = 0; m_age = 0;
               for (int i = 0; i < 6; i++) m_dig[i] = 0;
            end
         end else begin
            m_age++;
            if (pend && pcode < 4'd10) begin
               m_quiet = 0;
               if (int'(pcode) <= lim_of(m_cur, m_dig[0])) begin
                  m_dig[m_cur] = int'(pcode);
                  if (m_cur == 5) begin
                     m_state = 2;
                     e_load  = 1'b1;
                     e_ld    = 24'd0;
                     for (int i = 0; i < 6; i++) e_ld = (e_ld << 4) | 24'(m_dig[i]);
                     m_cur = 0;
                  end else begin
                     m_cur++;
                  end
               end else begin
                  e_err = 1'b1;
               end
            end else if (pend && pcode == 4'd10) begin
               e_abort = 1'b1; m_state = 0; m_cur = 0;
            end else begin
               m_quiet++;
               if (m_quiet == T) begin e_abort = 1'b1; m_state = 0; m_cur = 0; end
            end
         end
         // Debounce: a press is the D-th consecutive high seen through the 2-edge synchronizer
         for (int i = 31; i > 0; i--) begin samp[i] = samp[i-1]; csamp[i] = csamp[i-1]; end
         samp[0] = key_valid; csamp[0] = key_code;
         pend = 1'b0;
         begin
            bit all_hi, all_lo;
            all_hi = 1'b1; all_lo = 1'b1;
            for (int i = 2; i <= D + 1; i++) begin
               if (!samp[i]) all_hi = 1'b0;
               if (samp[i])  all_lo = 1'b0;
            end
            if (armed && all_hi) begin pend = 1'b1; pcode = csamp[2]; armed = 1'b0; end
            else if (!armed && all_lo) armed = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("load",        32'(load),        32'(e_load));
         chk("load_digits", 32'(load_digits), 32'(e_ld));
         chk("editing",     32'(editing),     32'(m_state == 1));
         chk("cursor",      32'(cursor),      (m_state == 1) ? 32'(m_cur) : 32'd0);
         chk("blink",       32'(blink),       (m_state == 1) ? 32'(((m_age / BH) % 2) == 0) : 32'd0);
         chk("err",         32'(err),         32'(e_err));
         chk("abort",       32'(abort),       32'(e_abort));
      end
   end

   // ---------------- event counters from DUT outputs ----------------
   int n_load = 0, n_err = 0, n_abort = 0, n_rise = 0, n_edit = 0;
   int cur_seen = 0;
   logic prev_edit = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         n_load  += int'(load);
         n_err   += int'(err);
         n_abort += int'(abort);
         n_edit  += int'(editing);
         if (editing && !prev_edit) n_rise++;
         if (editing) cur_seen = cur_seen | (1 << cursor);
      end
      prev_edit = editing;
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input logic [3:0] c, input int hold, input int gap);
      @(negedge clk);
      key_valid = 1'b1; key_code = c;
      repeat (hold) @(negedge clk);
      key_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_load"},    32'(load),        32'd0);
      chk({tag, "_digits"},  32'(load_digits), 32'd0);
      chk({tag, "_editing"}, 32'(editing),     32'd0);
      chk({tag, "_cursor"},  32'(cursor),      32'd0);
      chk({tag, "_blink"},   32'(blink),       32'd0);
      chk({tag, "_err"},     32'(err),         32'd0);
      chk({tag, "_abort"},   32'(abort),       32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      int b_load, b_err, b_abort, b_rise, b_edit;
      rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
      idle(3);
      chk_zero("reset");
      @(posedge clk); #2 rst = 1'b0;
      idle(4);

      // Full entry 23:59:59
      b_load = n_load; cur_seen = 0;
      key(4'd11, 4, 5);
      key(4'd2, 4, 5); key(4'd3, 4, 5); key(4'd5, 4, 5);
      key(4'd9, 4, 5); key(4'd5, 4, 5); key(4'd9, 4, 5);
      idle(4);
      chk("full_load_count", 32'(n_load - b_load), 32'd1);
      chk("full_digits",     32'(load_digits),     32'h235959);
      chk("full_cursor_seq", 32'(cur_seen),        32'h3f);

      // Range rejection
      b_err = n_err;
      key(4'd11, 4, 5);
      key(4'd3, 4, 5);
      chk("rng_err_c0", 32'(n_err - b_err), 32'd1);
      chk("rng_cur_c0", 32'(cursor),        32'd0);
      key(4'd2, 4, 5);
      key(4'd4, 4, 5);
      chk("rng_err_c1", 32'(n_err - b_err), 32'd2);
      chk("rng_cur_c1", 32'(cursor),        32'd1);
      key(4'd3, 4, 5);
      chk("rng_cur_c2", 32'(cursor),        32'd2);
      key(4'd10, 4, 5);

      // Cancel
      key(4'd11, 4, 5);
      key(4'd1, 4, 5);
      b_abort = n_abort; b_load = n_load;
      key(4'd10, 4, 5);
      chk("cancel_abort",  32'(n_abort - b_abort), 32'd1);
      chk("cancel_noload", 32'(n_load - b_load),   32'd0);
      chk("cancel_digits", 32'(load_digits),       32'h235959);

      // Timeout
      b_abort = n_abort; b_edit = n_edit;
      key(4'd11, 4, 0);
      for (int k = 0; k < 200; k++) begin
         if (n_abort != b_abort) break;
         @(negedge clk);
      end
      idle(2);
      chk("tmo_abort",      32'(n_abort - b_abort), 32'd1);
      chk("tmo_edit_cycles", 32'(n_edit - b_edit),  32'(T));
      chk("tmo_idle",       32'(editing),           32'd0);

      // Debounce: glitch, long hold, short re-press
      b_rise = n_rise;
      @(negedge clk); key_valid = 1'b1; key_code = 4'd11;
      @(negedge clk); key_valid = 1'b0;
      idle(8);
      chk("glitch_no_event", 32'(n_rise - b_rise), 32'd0);
      @(negedge clk); key_valid = 1'b1;
      idle(200);
      key_valid = 1'b0;
      @(negedge clk); key_valid = 1'b1;
      idle(10);
      key_valid = 1'b0;
      idle(10);
      chk("hold_one_event", 32'(n_rise - b_rise), 32'd1);

      // Async reset in the middle of an entry
      key(4'd11, 4, 5);
      key(4'd1, 4, 5); key(4'd2, 4, 5); key(4'd3, 4, 5);
      chk("pre_reset_cursor", 32'(cursor), 32'd3);
      @(negedge clk); #2 rst = 1'b1;
      #1 chk_zero("midrst");
      @(posedge clk); #2 rst = 1'b0;
      b_load = n_load;
      key(4'd1, 4, 5); key(4'd2, 4, 5);
      chk("postrst_editing", 32'(editing),         32'd0);
      chk("postrst_digits",  32'(load_digits),     32'd0);
      chk("postrst_noload",  32'(n_load - b_load), 32'd0);

      // Randomized traffic, with periodic legal sessions to reach COMMIT
      for (int i = 0; i < 120; i++) begin
         int r, h, g;
         logic [3:0] c;
         if (i % 10 == 0) begin
            int d [0:5];
            d[0] = $urandom_range(0, 2);
            d[1] = $urandom_range(0, (d[0] == 2) ? 3 : 9);
            d[2] = $urandom_range(0, 5); d[3] = $urandom_range(0, 9);
            d[4] = $urandom_range(0, 5); d[5] = $urandom_range(0, 9);
            key(4'd11, 3, 2);
            for (int j = 0; j < 6; j++) key(4'(d[j]), 3, 2);
         end
         r = $urandom_range(0, 99);
         if (r < 25)      c = 4'd11;
         else if (r < 32) c = 4'd10;
         else if (r < 38) c = 4'(12 + $urandom_range(0, 3));
         else             c = 4'($urandom_range(0, 9));
         h = $urandom_range(1, 6);
         g = $urandom_range(1, 6);
         if ($urandom_range(0, 19) == 0) g = 60;
         key(c, h, g);
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
